// File: rtl/ipv4_header_capture.sv
// Collects the first five 32-bit words of each packet into a 160-bit IPv4 header beat,
// rejects malformed or short headers and drops the payload.

module ipv4_sat_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

module ipv4_header_capture #(
  parameter int CNT_WIDTH = 16,
  parameter int IN_W      = 32,
  parameter int HDR_W     = 160
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_in_tvalid,
  output logic                 pkt_in_tready,
  input  logic [IN_W-1:0]      pkt_in_tdata,
  input  logic                 pkt_in_tlast,
  output logic                 ipv4_header_tvalid,
  input  logic                 ipv4_header_tready,
  output logic [HDR_W-1:0]     ipv4_header_tdata,
  output logic [CNT_WIDTH-1:0] hdr_count,
  output logic [CNT_WIDTH-1:0] short_count,
  output logic [CNT_WIDTH-1:0] fmt_err_count
);
  generate
    if (IN_W != 32 || HDR_W != 160) begin : g_width_check
      $error("ipv4_header_capture: stream widths must be 32 and 160");
    end
  endgenerate

  typedef enum logic [1:0] {CAPTURE, HOLD, SKIP} state_t;

  state_t          state, next_state;
  logic [2:0]      idx, next_idx;
  logic            skip_q, next_skip;
  logic [4:0][31:0] hdr_q;   // hdr_q[4] holds header word 0 (MSB of the beat)
  logic            tready_q, tvalid_q;
  logic            xfer, fmt_ok;
  logic [2:0]      inc_vec;
  logic [2:0][CNT_WIDTH-1:0] cnt_vec;

  assign xfer   = pkt_in_tvalid && tready_q;
  assign fmt_ok = (hdr_q[4][31:24] == 8'h45);

  assign pkt_in_tready      = tready_q;
  assign ipv4_header_tvalid = tvalid_q;
  assign ipv4_header_tdata  = hdr_q;

  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_skip  = skip_q;
    inc_vec    = 3'b000;
    case (state)
      CAPTURE: begin
        if (xfer) begin
          if (idx == 3'd4) begin
            next_idx = 3'd0;
            if (fmt_ok) begin
              next_state = HOLD;
              next_skip  = !pkt_in_tlast;
            end else begin
              inc_vec[2] = 1'b1;
              next_state = pkt_in_tlast ? CAPTURE : SKIP;
            end
          end else if (pkt_in_tlast) begin
            inc_vec[1] = 1'b1;
            next_idx   = 3'd0;
          end else begin
            next_idx = idx + 3'd1;
          end
        end
      end
      HOLD: begin
        if (ipv4_header_tready) begin
          inc_vec[0] = 1'b1;
          next_state = skip_q ? SKIP : CAPTURE;
        end
      end
      SKIP: begin
        if (xfer && pkt_in_tlast) next_state = CAPTURE;
      end
      default: next_state = CAPTURE;
    endcase
  end

  // Handshake flags are registered from the next state so the header is
  // presented exactly one cycle after the fifth word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CAPTURE;
      idx      <= 3'd0;
      skip_q   <= 1'b0;
      hdr_q    <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state    <= next_state;
      idx      <= next_idx;
      skip_q   <= next_skip;
      tready_q <= (next_state != HOLD);
      tvalid_q <= (next_state == HOLD);
      if (state == CAPTURE && xfer) hdr_q[3'd4 - idx] <= pkt_in_tdata;
    end
  end

  generate
    for (genvar i = 0; i < 3; i++) begin : g_cnt
      ipv4_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_vec[i]),
        .cnt   (cnt_vec[i])
      );
    end
  endgenerate

  assign hdr_count     = cnt_vec[0];
  assign short_count   = cnt_vec[1];
  assign fmt_err_count = cnt_vec[2];
endmodule

// File: tb/tb_ipv4_header_capture.sv
// Scoreboard bench for ipv4_header_capture: expected headers are queued when
// driven and compared when the output handshake is seen.

module tb_ipv4_header_capture;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld = 1'b0, in_rdy, in_last = 1'b0;
  logic [31:0]   in_data = '0;
  logic          out_vld, out_rdy = 1'b1;
  logic [159:0]  out_data;
  logic [CW-1:0] hdr_count, short_count, fmt_err_count;

  int checks = 0, errors = 0;
  logic [159:0] sb_q[$];
  int exp_hdr = 0;

  localparam logic [159:0] H1 = 160'h45000054_1c464000_40060000_ac100a63_ac100a0c;
  localparam logic [159:0] H2 = 160'h45000030_00010000_40110000_c0a80001_c0a80002;
  localparam logic [159:0] BADIHL = 160'h46000058_00020000_40060000_0a000001_0a000002;
  localparam logic [159:0] BADVER = 160'h65000054_00030000_40060000_0a000003_0a000004;

  ipv4_header_capture #(.CNT_WIDTH(CW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pkt_in_tvalid      (in_vld),
    .pkt_in_tready      (in_rdy),
    .pkt_in_tdata       (in_data),
    .pkt_in_tlast       (in_last),
    .ipv4_header_tvalid (out_vld),
    .ipv4_header_tready (out_rdy),
    .ipv4_header_tdata  (out_data),
    .hdr_count          (hdr_count),
    .short_count        (short_count),
    .fmt_err_count      (fmt_err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      if (sb_q.size() == 0) chk("unexpected_hdr", 160'd1, 160'd0);
      else                  chk("hdr_data", out_data, sb_q.pop_front());
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that took the word.
  task automatic send_word(input logic [31:0] d, input logic last);
    int t = 0;
    in_vld = 1'b1; in_data = d; in_last = last;
    do begin @(negedge clk); t++; end while (!in_rdy && t < 200);
    if (!in_rdy) chk("in_timeout", {159'd0, in_rdy}, 160'd1);
    @(posedge clk); #1;
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_hdr(input logic [159:0] h, input logic last);
    for (int i = 0; i < 5; i++) send_word(h[159-32*i -: 32], last && i == 4);
  endtask

  task automatic send_payload(input int n);
    for (int i = 0; i < n; i++) send_word(32'hdead0000 + i, i == n - 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_rdy", {159'd0, in_rdy}, 160'd0);
    chk("rst_out_vld", {159'd0, out_vld}, 160'd0);
    chk("rst_out_data", out_data, 160'd0);
    chk("rst_hdr_cnt", {144'd0, hdr_count}, 160'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_rdy_after_rst", {159'd0, in_rdy}, 160'd1);

    // Valid header, no payload; tvalid one cycle after fifth word
    sb_q.push_back(H1); exp_hdr++;
    send_hdr(H1, 1'b1);
    chk("lat_tvalid", {159'd0, out_vld}, 160'd1);
    chk("hold_in_rdy", {159'd0, in_rdy}, 160'd0);
    cycles(1);
    chk("hold_one_cycle", {159'd0, out_vld}, 160'd0);
    cycles(2);
    chk("hdr_cnt_t1", {144'd0, hdr_count}, 160'(exp_hdr));

    // Packet with payload, next packet back to back
    sb_q.push_back(H1); exp_hdr++;
    send_hdr(H1, 1'b0);
    send_payload(3);
    sb_q.push_back(H2); exp_hdr++;
    send_hdr(H2, 1'b1);
    cycles(3);
    chk("hdr_cnt_t2", {144'd0, hdr_count}, 160'(exp_hdr));

    // Downstream backpressure for 10 cycles
    out_rdy = 1'b0;
    sb_q.push_back(H2); exp_hdr++;
    send_hdr(H2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_vld", {159'd0, out_vld}, 160'd1);
      chk("bp_data", out_data, H2);
      chk("bp_in_rdy", {159'd0, in_rdy}, 160'd0);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    send_payload(2);
    cycles(2);
    chk("hdr_cnt_t3", {144'd0, hdr_count}, 160'(exp_hdr));
    chk("bp_vld_drop", {159'd0, out_vld}, 160'd0);

    // Short packet then a valid one
    send_word(32'h45000054, 1'b0);
    send_word(32'h1c464000, 1'b0);
    send_word(32'h40060000, 1'b1);
    cycles(1);
    chk("short_cnt", {144'd0, short_count}, 160'd1);
    chk("short_no_out", {159'd0, out_vld}, 160'd0);
    sb_q.push_back(H1); exp_hdr++;
    send_hdr(H1, 1'b1);
    cycles(3);
    chk("hdr_cnt_t4", {144'd0, hdr_count}, 160'(exp_hdr));

    // Format errors drained through SKIP, followed by a good header
    send_hdr(BADIHL, 1'b0);
    chk("ihl_no_out", {159'd0, out_vld}, 160'd0);
    send_payload(2);
    send_hdr(BADVER, 1'b0);
    chk("ver_no_out", {159'd0, out_vld}, 160'd0);
    send_payload(1);
    sb_q.push_back(H2); exp_hdr++;
    send_hdr(H2, 1'b1);
    cycles(3);
    chk("fmt_cnt", {144'd0, fmt_err_count}, 160'd2);
    chk("hdr_cnt_t5", {144'd0, hdr_count}, 160'(exp_hdr));
    chk("short_cnt_kept", {144'd0, short_count}, 160'd1);

    // Reset mid-capture
    send_word(32'h45000054, 1'b0);
    send_word(32'h1c464000, 1'b0);
    send_word(32'h40060000, 1'b0);
    rst_n = 1'b0;
    #3;
    chk("mid_rst_in_rdy", {159'd0, in_rdy}, 160'd0);
    chk("mid_rst_vld", {159'd0, out_vld}, 160'd0);
    chk("mid_rst_data", out_data, 160'd0);
    chk("mid_rst_cnts", {112'd0, hdr_count, short_count, fmt_err_count}, 160'd0);
    cycles(2);
    rst_n = 1'b1;
    exp_hdr = 0;
    cycles(1);
    sb_q.push_back(H1); exp_hdr++;
    send_hdr(H1, 1'b1);
    cycles(3);
    chk("hdr_cnt_t6", {144'd0, hdr_count}, 160'(exp_hdr));
    chk("sb_empty", 160'(sb_q.size()), 160'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
